instruction_fetch: RTL and testbench



---
 rtl/instruction_fetch_if.sv | 33 +++
 rtl/instruction_fetch.sv | 123 ++++++++++++
 tb/tb_instruction_fetch.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Debug-unit <-> IF stage bus: step/stall/jump control, program-load
// byte stream, and the IF/ID latch plus status readouts.
interface instruction_fetch_if #(
  parameter int NB     = 32,
  parameter int ADDR_W = 6
);
  logic              i_step;
  logic              i_stall;
  logic              i_jump;
  logic [NB-1:0]     i_jump_addr;
  logic              i_load_en;
  logic              i_load_valid;
  logic [7:0]        i_load_byte;
  logic [NB-1:0]     o_Instruction;
  logic [NB-1:0]     o_pc4;
  logic [NB-1:0]     o_pc;
  logic              o_halt;
  logic [ADDR_W:0]   o_load_words;

  // Debug unit / testbench side: drives control and load stream.
  modport master (
    output i_step, i_stall, i_jump, i_jump_addr,
    output i_load_en, i_load_valid, i_load_byte,
    input  o_Instruction, o_pc4, o_pc, o_halt, o_load_words
  );

  // Fetch stage side.
  modport slave (
    input  i_step, i_stall, i_jump, i_jump_addr,
    input  i_load_en, i_load_valid, i_load_byte,
    output o_Instruction, o_pc4, o_pc, o_halt, o_load_words
  );
endinterface

// File: rtl/instruction_fetch.sv
// MIPS IF stage: PC, word-addressed instruction memory filled byte-wise
// over UART, single-step fetch into the IF/ID latch, sticky HALT detect.
module instruction_fetch #(
  parameter int            NB        = 32,
  parameter int            MEM_WORDS = 64,
  parameter int            ADDR_W    = 6,
  parameter logic [NB-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  instruction_fetch_if.slave bus
);

  localparam logic [ADDR_W:0] WORDS_MAX = (ADDR_W+1)'(MEM_WORDS);

  logic [NB-1:0] mem [MEM_WORDS];

  // Load-path state. The completed-word count doubles as the write pointer,
  // since both start at zero and advance together.
  logic [1:0]      byte_cnt_q, byte_cnt_d;
  logic [23:0]     asm_q, asm_d;
  logic [ADDR_W:0] load_words_q, load_words_d;
  logic            mem_we;
  logic [NB-1:0]   mem_wdata;

  // Fetch-path state.
  logic [NB-1:0]   pc_q, pc_d;
  logic [NB-1:0]   pc4_q, pc4_d;
  logic [NB-1:0]   instr_q, instr_d;
  logic            halt_q, halt_d;

  logic [NB-1:0]   fetch_word;
  logic [NB-1:0]   pc_plus4;
  logic            out_of_range;

  // Big-endian byte assembly; the 4th byte completes the word and writes it
  // unless memory is already full.
  always_comb begin
    byte_cnt_d   = byte_cnt_q;
    asm_d        = asm_q;
    load_words_d = load_words_q;
    mem_we       = 1'b0;
    mem_wdata    = {asm_q, bus.i_load_byte};
    if (bus.i_load_en && bus.i_load_valid) begin
      if (byte_cnt_q == 2'd3) begin
        byte_cnt_d = 2'd0;
        if (load_words_q < WORDS_MAX) begin
          mem_we       = 1'b1;
          load_words_d = load_words_q + 1'b1;
        end
      end else begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        asm_d      = {asm_q[15:0], bus.i_load_byte};
      end
    end
  end

  // Combinational read; PCs beyond the memory read as HALT so runaway
  // programs stop instead of wrapping.
  always_comb begin
    out_of_range = (pc_q[NB-1:ADDR_W+2] != '0);
    fetch_word   = out_of_range ? HALT_WORD : mem[pc_q[ADDR_W+1:2]];
    pc_plus4     = pc_q + NB'(4);
  end

  // One fetch per step pulse: load mode, stall and halt all freeze the
  // stage; a jump flushes the latch with a NOP and redirects the PC.
  always_comb begin
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    halt_d  = halt_q;
    if (bus.i_step && !bus.i_load_en && !bus.i_stall && !halt_q) begin
      if (bus.i_jump) begin
        pc_d    = bus.i_jump_addr;
        instr_d = '0;
      end else begin
        instr_d = fetch_word;
        pc4_d   = pc_plus4;
        if (fetch_word == HALT_WORD) begin
          halt_d = 1'b1;
        end else begin
          pc_d = pc_plus4;
        end
      end
    end
  end

  // Register all load and fetch state; reset discards any partial word.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      byte_cnt_q   <= '0;
      asm_q        <= '0;
      load_words_q <= '0;
      pc_q         <= '0;
      pc4_q        <= '0;
      instr_q      <= '0;
      halt_q       <= 1'b0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      load_words_q <= load_words_d;
      pc_q         <= pc_d;
      pc4_q        <= pc4_d;
      instr_q      <= instr_d;
      halt_q       <= halt_d;
    end
  end

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge i_clk) begin
    if (mem_we) begin
      mem[load_words_q[ADDR_W-1:0]] <= mem_wdata;
    end
  end

  assign bus.o_Instruction = instr_q;
  assign bus.o_pc4         = pc4_q;
  assign bus.o_pc          = pc_q;
  assign bus.o_halt        = halt_q;
  assign bus.o_load_words  = load_words_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: load, step, stall/jump priority,
// out-of-range halt, reset mid-load, idle stability, load saturation.
module tb_instruction_fetch;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  instruction_fetch_if #(.NB(32), .ADDR_W(6)) bus ();

  instruction_fetch dut (
    .i_clk   (clk),
    .i_reset (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one load byte for a single clock.
  task automatic applyStimulus(input logic [7:0] b);
    @(negedge clk);
    bus.i_load_en    = 1'b1;
    bus.i_load_valid = 1'b1;
    bus.i_load_byte  = b;
    @(negedge clk);
    bus.i_load_valid = 1'b0;
  endtask

  task automatic loadWord(input logic [31:0] w);
    applyStimulus(w[31:24]);
    applyStimulus(w[23:16]);
    applyStimulus(w[15:8]);
    applyStimulus(w[7:0]);
  endtask

  // One step pulse with the given control inputs.
  task automatic stepOnce(input logic stall, input logic jump,
                          input logic [31:0] addr);
    @(negedge clk);
    bus.i_stall     = stall;
    bus.i_jump      = jump;
    bus.i_jump_addr = addr;
    bus.i_step      = 1'b1;
    @(negedge clk);
    bus.i_step  = 1'b0;
    bus.i_stall = 1'b0;
    bus.i_jump  = 1'b0;
  endtask

  task automatic pulseReset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    bus.i_step = 0; bus.i_stall = 0; bus.i_jump = 0; bus.i_jump_addr = '0;
    bus.i_load_en = 0; bus.i_load_valid = 0; bus.i_load_byte = '0;
    rst_n = 1'b0;
    #12;
    checkOutput("rst_pc",    bus.o_pc, 32'h0);
    checkOutput("rst_pc4",   bus.o_pc4, 32'h0);
    checkOutput("rst_instr", bus.o_Instruction, 32'h0);
    checkOutput("rst_halt",  {31'b0, bus.o_halt}, 32'h0);
    checkOutput("rst_words", {25'b0, bus.o_load_words}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Program load
    loadWord(32'h2008_0005);
    loadWord(32'h2009_0007);
    loadWord(32'hFFFF_FFFF);
    checkOutput("load_words3", {25'b0, bus.o_load_words}, 32'd3);

    // Fetch inhibited in load mode
    stepOnce(1'b0, 1'b0, 32'h0);
    checkOutput("loaden_pc", bus.o_pc, 32'h0);
    checkOutput("loaden_instr", bus.o_Instruction, 32'h0);
    bus.i_load_en = 1'b0;

    stepOnce(1'b0, 1'b0, 32'h0);
    checkOutput("s1_instr", bus.o_Instruction, 32'h2008_0005);
    checkOutput("s1_pc4",   bus.o_pc4, 32'd4);
    checkOutput("s1_pc",    bus.o_pc, 32'd4);
    stepOnce(1'b0, 1'b0, 32'h0);
    checkOutput("s2_instr", bus.o_Instruction, 32'h2009_0007);
    checkOutput("s2_pc",    bus.o_pc, 32'd8);
    checkOutput("s2_pc4",   bus.o_pc4, 32'd8);
    stepOnce(1'b0, 1'b0, 32'h0);
    checkOutput("s3_instr", bus.o_Instruction, 32'hFFFF_FFFF);
    checkOutput("s3_halt",  {31'b0, bus.o_halt}, 32'd1);
    checkOutput("s3_pc",    bus.o_pc, 32'd8);
    checkOutput("s3_pc4",   bus.o_pc4, 32'd12);
    // Halt outranks jump
    stepOnce(1'b0, 1'b1, 32'h0000_0010);
    checkOutput("s4_pc",    bus.o_pc, 32'd8);
    checkOutput("s4_instr", bus.o_Instruction, 32'hFFFF_FFFF);
    checkOutput("s4_pc4",   bus.o_pc4, 32'd12);
    checkOutput("s4_halt",  {31'b0, bus.o_halt}, 32'd1);

    // Idle: no step, load_valid toggling outside load mode
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.i_load_valid = ~bus.i_load_valid;
      bus.i_load_byte  = 8'(i);
      checkOutput("idle_pc", bus.o_pc, 32'd8);
    end
    bus.i_load_valid = 1'b0;
    checkOutput("idle_instr", bus.o_Instruction, 32'hFFFF_FFFF);
    checkOutput("idle_pc4",   bus.o_pc4, 32'd12);
    checkOutput("idle_halt",  {31'b0, bus.o_halt}, 32'd1);
    checkOutput("idle_words", {25'b0, bus.o_load_words}, 32'd3);

    // Stall outranks jump, then jump flushes
    pulseReset();
    checkOutput("rst2_halt", {31'b0, bus.o_halt}, 32'd0);
    checkOutput("rst2_pc", bus.o_pc, 32'd0);
    stepOnce(1'b0, 1'b0, 32'h0);
    checkOutput("pre_stall_pc", bus.o_pc, 32'd4);
    stepOnce(1'b1, 1'b1, 32'h0000_0020);
    checkOutput("stall_pc",    bus.o_pc, 32'd4);
    checkOutput("stall_instr", bus.o_Instruction, 32'h2008_0005);
    stepOnce(1'b0, 1'b1, 32'h0);
    checkOutput("jump_pc",    bus.o_pc, 32'd0);
    checkOutput("jump_instr", bus.o_Instruction, 32'h0);
    checkOutput("jump_pc4",   bus.o_pc4, 32'd4);

    // Out-of-range fetch halts
    stepOnce(1'b0, 1'b1, 32'h0000_0400);
    checkOutput("oor_jump_pc", bus.o_pc, 32'h0000_0400);
    stepOnce(1'b0, 1'b0, 32'h0);
    checkOutput("oor_instr", bus.o_Instruction, 32'hFFFF_FFFF);
    checkOutput("oor_halt",  {31'b0, bus.o_halt}, 32'd1);
    checkOutput("oor_pc",    bus.o_pc, 32'h0000_0400);
    checkOutput("oor_pc4",   bus.o_pc4, 32'h0000_0404);

    // Reset mid-word discards the partial bytes
    pulseReset();
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    pulseReset();
    loadWord(32'hAABB_CCDD);
    checkOutput("midrst_words", {25'b0, bus.o_load_words}, 32'd1);
    bus.i_load_en = 1'b0;
    stepOnce(1'b0, 1'b0, 32'h0);
    checkOutput("midrst_mem0", bus.o_Instruction, 32'hAABB_CCDD);
    stepOnce(1'b0, 1'b0, 32'h0);
    checkOutput("midrst_mem1_kept", bus.o_Instruction, 32'h2009_0007);

    // Saturation: 65th word is dropped
    pulseReset();
    for (int i = 0; i < 64; i++) loadWord({8'h10, 24'(i)});
    checkOutput("sat_words64", {25'b0, bus.o_load_words}, 32'd64);
    loadWord(32'hDEAD_BEEF);
    checkOutput("sat_words_hold", {25'b0, bus.o_load_words}, 32'd64);
    bus.i_load_en = 1'b0;
    stepOnce(1'b0, 1'b0, 32'h0);
    checkOutput("sat_mem0", bus.o_Instruction, 32'h1000_0000);
    stepOnce(1'b0, 1'b1, 32'h0000_00FC);
    stepOnce(1'b0, 1'b0, 32'h0);
    checkOutput("sat_mem63", bus.o_Instruction, 32'h1000_003F);
    checkOutput("wrap_pc", bus.o_pc, 32'h0000_0100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
